// File: rtl/tmul_pkg.sv
// Shared TMUL datapath definitions: tile geometry, the FP16 element and
// product-row types, the C-tile drain state encoding and an index-width
// helper used to size row/beat pointers.
package tmul_pkg;

    localparam int unsigned ELEM_W = 16;   // bits per FP16 element
    localparam int unsigned N_COLS = 32;   // elements per product row
    localparam int unsigned N_ROWS = 16;   // rows per C tile
    localparam int unsigned OUT_W  = 256;  // drain beat width

    typedef logic [15:0] fp16_t;
    typedef fp16_t [N_COLS-1:0] row_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Pointer width for an index over n items; never narrower than 1 bit.
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_c_drain_if.sv
// Row-capture and drain-beat handshake bundle for tile_c_drain.
//   row_valid/row_data/row_ready : RowProduct input (producer -> block)
//   out_valid/out_data/out_ready : drain beats (block -> downstream)
//   out_row/out_beat/out_last    : position of the current beat in the tile
//   tile_done                    : one-cycle pulse after the final beat
// master = producer/consumer side (testbench or surrounding datapath),
// slave  = tile_c_drain.
interface tile_c_drain_if #(
    parameter int unsigned ELEM_W = tmul_pkg::ELEM_W,
    parameter int unsigned N_COLS = tmul_pkg::N_COLS,
    parameter int unsigned N_ROWS = tmul_pkg::N_ROWS,
    parameter int unsigned OUT_W  = tmul_pkg::OUT_W
);

    localparam int unsigned ROW_BITS = N_COLS * ELEM_W;
    localparam int unsigned BEATS    = ROW_BITS / OUT_W;
    localparam int unsigned ROW_W    = tmul_pkg::idxWidth(N_ROWS);
    localparam int unsigned BEAT_W   = tmul_pkg::idxWidth(BEATS);

    logic                row_valid;
    logic [ROW_BITS-1:0] row_data;
    logic                row_ready;
    logic                out_valid;
    logic [OUT_W-1:0]    out_data;
    logic                out_ready;
    logic [ROW_W-1:0]    out_row;
    logic [BEAT_W-1:0]   out_beat;
    logic                out_last;
    logic                tile_done;

    modport master (
        output row_valid, row_data, out_ready,
        input  row_ready, out_valid, out_data, out_row, out_beat, out_last, tile_done
    );

    modport slave (
        input  row_valid, row_data, out_ready,
        output row_ready, out_valid, out_data, out_row, out_beat, out_last, tile_done
    );

endinterface

// File: rtl/tile_c_row_buf.sv
// C tile buffer: N_ROWS x row-wide register file.
//   clk           : rising-edge clock
//   we/wrAddr/wrData : full-row write port
//   rdAddr/rdBeat : combinational read of one OUT_W beat of one row
//   rdData        : selected beat
// Contents are deliberately not reset.
module tile_c_row_buf #(
    parameter int unsigned ROW_BITS = tmul_pkg::N_COLS * tmul_pkg::ELEM_W,
    parameter int unsigned N_ROWS   = tmul_pkg::N_ROWS,
    parameter int unsigned OUT_W    = tmul_pkg::OUT_W
) (
    input  logic                                        clk,
    input  logic                                        we,
    input  logic [tmul_pkg::idxWidth(N_ROWS)-1:0]       wrAddr,
    input  logic [ROW_BITS-1:0]                         wrData,
    input  logic [tmul_pkg::idxWidth(N_ROWS)-1:0]       rdAddr,
    input  logic [tmul_pkg::idxWidth(ROW_BITS/OUT_W)-1:0] rdBeat,
    output logic [OUT_W-1:0]                            rdData
);

    localparam int unsigned BEATS = ROW_BITS / OUT_W;

    // Each row is held as BEATS packed beats so beat b is bits [(b+1)*OUT_W-1 : b*OUT_W].
    logic [BEATS-1:0][OUT_W-1:0] mem [N_ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr][rdBeat];

endmodule

// File: rtl/tile_c_drain.sv
// tile_c_drain: captures N_ROWS RowProduct rows from TMUL_fma into a C tile
// buffer, then drains the tile as OUT_W-wide beats (row-major, beat 0 first).
// Fill and drain alternate on a single buffer and never overlap.
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset; all outputs are 0 while low
//   bus  : tile_c_drain_if.slave (row input handshake, drain handshake,
//          beat position, tile_done pulse)
module tile_c_drain #(
    parameter int unsigned ELEM_W = tmul_pkg::ELEM_W,
    parameter int unsigned N_COLS = tmul_pkg::N_COLS,
    parameter int unsigned N_ROWS = tmul_pkg::N_ROWS,
    parameter int unsigned OUT_W  = tmul_pkg::OUT_W
) (
    input logic          clk,
    input logic          rst,
    tile_c_drain_if.slave bus
);

    import tmul_pkg::*;

    localparam int unsigned ROW_BITS = N_COLS * ELEM_W;
    localparam int unsigned BEATS    = ROW_BITS / OUT_W;
    localparam int unsigned ROW_W    = idxWidth(N_ROWS);
    localparam int unsigned BEAT_W   = idxWidth(BEATS);

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N_ROWS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    drain_state_e      stateQ, stateD;
    logic [ROW_W-1:0]  wrRowQ, wrRowD;
    logic [ROW_W-1:0]  rdRowQ, rdRowD;
    logic [BEAT_W-1:0] rdBeatQ, rdBeatD;
    logic              tileDoneQ, tileDoneD;
    logic              rowWe;
    logic              bufWe;
    logic              inDrain;
    logic [OUT_W-1:0]  rdData;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ    <= FILL;
            wrRowQ    <= '0;
            rdRowQ    <= '0;
            rdBeatQ   <= '0;
            tileDoneQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            wrRowQ    <= wrRowD;
            rdRowQ    <= rdRowD;
            rdBeatQ   <= rdBeatD;
            tileDoneQ <= tileDoneD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        wrRowD    = wrRowQ;
        rdRowD    = rdRowQ;
        rdBeatD   = rdBeatQ;
        tileDoneD = 1'b0;
        rowWe     = 1'b0;
        case (stateQ)
            FILL: begin
                // out_ready is ignored here; only row acceptance advances state.
                if (bus.row_valid) begin
                    rowWe = 1'b1;
                    if (wrRowQ == LAST_ROW) begin
                        wrRowD = '0;
                        stateD = DRAIN;
                    end else begin
                        wrRowD = wrRowQ + ROW_W'(1);
                    end
                end
            end
            DRAIN: begin
                // row_valid is ignored here; upstream holds its row until FILL.
                if (bus.out_ready) begin
                    if (rdBeatQ == LAST_BEAT) begin
                        rdBeatD = '0;
                        if (rdRowQ == LAST_ROW) begin
                            rdRowD    = '0;
                            stateD    = FILL;
                            tileDoneD = 1'b1;
                        end else begin
                            rdRowD = rdRowQ + ROW_W'(1);
                        end
                    end else begin
                        rdBeatD = rdBeatQ + BEAT_W'(1);
                    end
                end
            end
            default: stateD = FILL;
        endcase
    end

    // Suppress the buffer write on a reset edge so an abandoned row never lands.
    assign bufWe = rowWe && rst;

    tile_c_row_buf #(
        .ROW_BITS (ROW_BITS),
        .N_ROWS   (N_ROWS),
        .OUT_W    (OUT_W)
    ) uRowBuf (
        .clk    (clk),
        .we     (bufWe),
        .wrAddr (wrRowQ),
        .wrData (bus.row_data),
        .rdAddr (rdRowQ),
        .rdBeat (rdBeatQ),
        .rdData (rdData)
    );

    // Outputs come straight from registered state and pointers, so they hold
    // steady under drain backpressure; rst gates them to 0 combinationally.
    always_comb begin
        inDrain       = rst && (stateQ == DRAIN);
        bus.row_ready = rst && (stateQ == FILL);
        bus.out_valid = inDrain;
        bus.out_data  = inDrain ? rdData : '0;
        bus.out_row   = inDrain ? rdRowQ : '0;
        bus.out_beat  = inDrain ? rdBeatQ : '0;
        bus.out_last  = inDrain && (rdRowQ == LAST_ROW) && (rdBeatQ == LAST_BEAT);
        bus.tile_done = rst && tileDoneQ;
    end

endmodule

// File: tb/tb_tile_c_drain.sv
// Directed bench for tile_c_drain: a reference model of the fill/drain
// sequencing plus a beat scoreboard fed from accepted rows.
module tb_tile_c_drain;

    import tmul_pkg::*;

    localparam int unsigned ROW_BITS = N_COLS * ELEM_W;
    localparam int unsigned BEATS    = ROW_BITS / OUT_W;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [3:0]       row;
        logic [0:0]       beat;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    tile_c_drain_if bus ();

    tile_c_drain dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    beat_t       sb[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          modelFill   = 1'b1;
    int unsigned modelRow    = 0;
    bit          expDone     = 1'b0;
    int unsigned doneSeen    = 0;
    int unsigned beatsPopped = 0;

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic row_t patA(input int unsigned r);
        row_t x;
        for (int unsigned m = 0; m < N_COLS; m++) x[m] = 16'((r << 8) | m);
        return x;
    endfunction

    function automatic row_t patB(input int unsigned r);
        row_t x;
        for (int unsigned m = 0; m < N_COLS; m++) x[m] = 16'(32'hA000 | (r << 4) | (m & 32'hF));
        return x;
    endfunction

    function automatic row_t patRand();
        row_t x;
        for (int unsigned m = 0; m < N_COLS; m++) x[m] = 16'($urandom);
        return x;
    endfunction

    // One clock: predict what the upcoming edge does, advance, then check.
    task automatic tick();
        bit                  wasRst;
        bit                  rowAcc;
        bit                  beatAcc;
        logic [ROW_BITS-1:0] rowSnap;
        beat_t               e;
        wasRst  = (rst === 1'b0);
        rowAcc  = (bus.row_valid === 1'b1) && modelFill && !wasRst;
        beatAcc = (bus.out_ready === 1'b1) && !modelFill && !wasRst;
        rowSnap = bus.row_data;
        @(posedge clk);
        #1;
        expDone = 1'b0;
        if (wasRst) begin
            sb.delete();
            modelFill = 1'b1;
            modelRow  = 0;
        end else if (rowAcc) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                e.data = rowSnap[b*OUT_W +: OUT_W];
                e.row  = 4'(modelRow);
                e.beat = 1'(b);
                e.last = (modelRow == N_ROWS - 1) && (b == BEATS - 1);
                sb.push_back(e);
            end
            modelRow++;
            if (modelRow == N_ROWS) begin
                modelRow  = 0;
                modelFill = 1'b0;
            end
        end else if (beatAcc) begin
            if (sb.size() == 0) begin
                check("sbUnderflow", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                beatsPopped++;
                if (e.last) begin
                    modelFill = 1'b1;
                    expDone   = 1'b1;
                end
            end
        end
        if (bus.tile_done === 1'b1) doneSeen++;
        check("row_ready", bus.row_ready, modelFill && rst);
        check("out_valid", bus.out_valid, !modelFill && rst);
        check("tile_done", bus.tile_done, expDone);
        if (!modelFill && rst && sb.size() > 0) begin
            check("out_data", bus.out_data, sb[0].data);
            check("out_row",  bus.out_row,  sb[0].row);
            check("out_beat", bus.out_beat, sb[0].beat);
            check("out_last", bus.out_last, sb[0].last);
        end else if (!rst) begin
            check("rstRow",  bus.out_row,  '0);
            check("rstBeat", bus.out_beat, '0);
            check("rstLast", bus.out_last, '0);
        end
    endtask

    task automatic sendRow(input row_t r, input int unsigned gap);
        bit acc;
        bit done;
        done = 1'b0;
        bus.row_valid = 1'b1;
        bus.row_data  = r;
        for (int unsigned i = 0; i < 50 && !done; i++) begin
            acc = modelFill && (rst === 1'b1);
            tick();
            if (acc) done = 1'b1;
        end
        if (!done) check("sendTimeout", 1'b0, 1'b1);
        if (gap > 0) begin
            bus.row_valid = 1'b0;
            for (int unsigned g = 0; g < gap; g++) tick();
        end
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0 repeating; 2: random.
    task automatic drainTile(input int unsigned mode);
        for (int unsigned i = 0; i < 600 && !modelFill; i++) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (i % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
        end
        check("drainEnd", modelFill, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned doneBase;
        rst           = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_data  = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rstTileDone", bus.tile_done, 1'b0);
        check("rstOutValid", bus.out_valid, 1'b0);
        rst = 1'b1;
        tick();
        check("readyAfterRst", bus.row_ready, 1'b1);

        // Back-to-back fill with out_ready already high, then unstalled drain.
        bus.out_ready = 1'b1;
        beatsPopped   = 0;
        doneBase      = doneSeen;
        for (int unsigned r = 0; r < N_ROWS; r++) sendRow(patA(r), 0);
        bus.row_valid = 1'b0;
        check("firstValid", bus.out_valid, 1'b1);
        check("b0e0",  bus.out_data[15:0],    16'h0000);
        check("b0e15", bus.out_data[255:240], 16'h000F);
        tick();
        check("b1e16", bus.out_data[15:0], 16'h0010);
        drainTile(0);
        check("beatCount", beatsPopped, 32);
        check("doneOnce",  doneSeen - doneBase, 1);

        // Drain under backpressure.
        bus.out_ready = 1'b1;
        for (int unsigned r = 0; r < N_ROWS; r++) sendRow(patA(r), 0);
        bus.row_valid = 1'b0;
        drainTile(1);

        // Gapped fill: one row every third cycle.
        bus.out_ready = 1'b1;
        for (int unsigned r = 0; r < N_ROWS; r++) sendRow(patA(r + 16), 2);
        drainTile(0);

        // Rows offered during drain must be ignored.
        for (int unsigned r = 0; r < N_ROWS; r++) sendRow(patA(r + 32), 0);
        bus.row_data = {N_COLS{16'hDEAD}};
        drainTile(0);
        check("doneWithReady", {bus.tile_done, bus.row_ready}, 2'b11);
        bus.row_valid = 1'b0;

        // Reset mid-fill abandons the partial tile.
        for (int unsigned r = 0; r < 7; r++) sendRow(patA(r + 48), 0);
        bus.row_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midRstReady", bus.row_ready, 1'b0);
        check("midRstValid", bus.out_valid, 1'b0);
        tick();
        rst = 1'b1;
        for (int unsigned r = 0; r < N_ROWS; r++) sendRow(patB(r), 0);
        bus.row_valid = 1'b0;
        drainTile(0);

        // Two random tiles with random gaps and random backpressure.
        doneBase = doneSeen;
        for (int unsigned t = 0; t < 2; t++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            for (int unsigned r = 0; r < N_ROWS; r++) sendRow(patRand(), $urandom_range(0, 1));
            bus.row_valid = 1'b0;
            drainTile(2);
        end
        check("twoTiles", doneSeen - doneBase, 2);
        check("sbEmpty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tile_c_drain.md
Name: tile_c_drain

Overview:
- Output-side counterpart of tile_a, at the other end of the TMUL datapath.
- tile_a streams 16-element FP16 A rows into TMUL_fma. This block captures each 32-element FP16 RowProduct that TMUL_fma produces into a C tile buffer.
- Once the tile is complete, it drains the C tile to downstream storage as 256-bit beats over a valid/ready handshake.
- Single-buffered: fill phase and drain phase alternate and never overlap.

Parameters:
- ELEM_W, 16, bits per FP16 element.
- N_COLS, 32, elements per product row.
- N_ROWS, 16, rows per C tile.
- OUT_W, 256, drain beat width. Must divide N_COLS*ELEM_W. BEATS = N_COLS*ELEM_W/OUT_W, which is 2 at defaults.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset: synchronous, active-low (asserted when rst==0 at a rising clk edge).
- row_valid, in, 1, a RowProduct row is presented on row_data.
- row_data, in, N_COLS*ELEM_W, row; element m occupies [(m+1)*ELEM_W-1 : m*ELEM_W].
- row_ready, out, 1, block accepts a row this cycle.
- out_valid, out, 1, drain beat valid.
- out_data, out, OUT_W, drain beat; beat b of a row = row bits [(b+1)*OUT_W-1 : b*OUT_W].
- out_ready, in, 1, downstream accepts the beat.
- out_row, out, $clog2(N_ROWS), row index of the current beat.
- out_beat, out, $clog2(BEATS) (min 1), beat index within the row.
- out_last, out, 1, final beat of the tile.
- tile_done, out, 1, one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values (rst==0 at clk edge):
  - state=FILL, wr_row=0, rd_row=0, rd_beat=0.
  - row_ready=1 in the cycle after reset releases. While rst is low, all outputs are driven 0.
  - out_valid=0, out_last=0, tile_done=0, out_row=0, out_beat=0.
  - Buffer contents are not reset. out_data is don't-care while out_valid=0.
- Row acceptance: row_ready = (state==FILL). A row is accepted on an edge where row_valid && row_ready.
- FILL: on accept, buf[wr_row] <= row_data and wr_row increments.
  - Accepting the row with wr_row==N_ROWS-1 sets wr_row to 0 and state to DRAIN.
  - row_ready drops in the next cycle.
- DRAIN:
  - out_valid=1.
  - out_data = buf[rd_row] slice rd_beat, driven combinationally from registered pointers and buffer.
  - out_row=rd_row, out_beat=rd_beat.
  - out_last = (rd_row==N_ROWS-1 && rd_beat==BEATS-1).
- Drain handshake:
  - On out_valid && out_ready, rd_beat increments; it wraps to 0 and increments rd_row.
  - Beat order is row 0 beat 0, row 0 beat 1, row 1 beat 0, and so on.
  - If out_ready=0, out_data/out_row/out_beat/out_last must stay stable.
  - Accepting the out_last beat sets rd_row=rd_beat=0, state=FILL, and tile_done=1 for exactly the next cycle. row_ready=1 in that same cycle.
- Latency:
  - First out_valid is 1 cycle after the edge that accepts the N_ROWS-th row.
  - Minimum tile turnaround (fill + drain, both sides always ready) is N_ROWS + N_ROWS*BEATS cycles.
- Boundaries:
  - row_valid while row_ready=0 (DRAIN) is ignored, not stored. Upstream must hold the row.
  - out_ready asserted during FILL has no effect.
  - Rows arriving in back-to-back cycles are all accepted, one per cycle.
  - Reset mid-FILL or mid-DRAIN abandons the partial tile: pointers go to 0, state goes to FILL, and no tile_done is produced.
  - The FILL-to-DRAIN and DRAIN-to-FILL transitions never coincide; the state is always exactly one of the two.

Decomposition:
- Package tmul_pkg:
  - Constants ELEM_W/N_COLS/N_ROWS.
  - typedef fp16_t (logic [15:0]).
  - typedef row_t (fp16_t [N_COLS-1:0]).
  - enum drain_state_e {FILL, DRAIN}.
- Sub-module tile_c_row_buf:
  - N_ROWS x row-wide register file.
  - One write port (row wide, we + wr_addr).
  - One combinational read port selecting row rd_addr and beat rd_beat (OUT_W wide).
- Top-level tile_c_drain holds the FSM, pointers and handshake logic.

Test Plan:
- Reset then fill, out_ready=1:
  - Stimulus: row r element m = 16'h(r<<8 | m), 16 rows back-to-back.
  - Required: row_ready high for 16 cycles and low after; out_valid the next cycle.
  - Required: first beat out_data[15:0]=16'h0000, [255:240]=16'h000F; second beat [15:0]=16'h0010.
  - Required: 32 beats total, out_last on row 15 beat 1, tile_done pulse once.
- Drain backpressure: toggle out_ready 1,0,0,1,... during DRAIN. Required: out_data/out_row/out_beat unchanged while out_ready=0; beat sequence identical to the unstalled run.
- Gapped fill: row_valid asserted every 3rd cycle. Required: exactly 16 rows stored in order; DRAIN entered only after the 16th accept.
- Row during drain: row_valid=1 with data 16'hDEAD throughout DRAIN. Required: no buffer write; the drained tile matches the pre-drain rows; next FILL row_ready=1 in the same cycle as tile_done.
- Mid-op reset:
  - Stimulus: rst=0 for one edge after 7 rows accepted, then refill 16 rows with pattern 16'h(0xA000 | r<<4 | m[3:0]).
  - Required: no tile_done until all 16 new rows are in; drain returns only new-pattern data; out_valid=0 during reset.
- Back-to-back tiles: two full tiles with random FP16 data and random out_ready. Required: both tiles drained bit-exact vs a scoreboard; exactly 2 tile_done pulses.
